// File: rtl/posit_alu_seq.sv
// Registered ALU: add/sub/and/or/xor/cmp/mov in 1 cycle, shift-add MUL in WIDTH cycles after accept.
// Backpressure: result held while out_valid && !out_ready; in_ready drops while held or multiplying.
module posit_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             c,
  output logic             z,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             c_q, c_d, z_q, z_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && select == OP_MUL) state_d = S_MUL;
      S_MUL:   if (last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / handshake logic
  always_comb begin
    in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    busy      = (state_q == S_MUL);
    accept    = in_valid && in_ready;
    last_step = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));
    out       = out_q;
    out_valid = out_valid_q;
    c         = c_q;
    z         = z_q;
  end

  always_comb begin
    alu_res = '0;
    case (select)
      OP_ADD:  alu_res = in1 + in2;
      OP_SUB:  alu_res = in1 - in2;
      OP_AND:  alu_res = in1 & in2;
      OP_OR:   alu_res = in1 | in2;
      OP_XOR:  alu_res = in1 ^ in2;
      default: alu_res = in1;
    endcase
  end

  assign acc_step = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    z_d         = z_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (select == OP_MUL) begin
        a_d   = in1;
        b_d   = in2;
        acc_d = '0;
        cnt_d = '0;
      end else if (select == OP_CMP) begin
        out_d       = '0;
        out_valid_d = 1'b1;
        c_d         = (in1 > in2);
        z_d         = (in1 == in2);
      end else begin
        out_d       = alu_res;
        out_valid_d = 1'b1;
      end
    end

    // One multiplier bit per cycle: multiplicand shifts left, multiplier shifts right.
    if (state_q == S_MUL) begin
      acc_d = acc_step;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (last_step) begin
        out_d       = acc_step;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      z_q         <= z_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
